bcd_to_bin: RTL and testbench

Sequential BCD-to-binary decoder: the inverse of the display-path binary-to-BCD converter. It takes a packed 4-digit BCD value, typically from the user switches, and produces its 14-bit binary equivalent (0–9999) for data memory or the register file. Conversion uses reverse double-dabble, one bit per clock. A start/busy/done handshake lets the control unit sequence it.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adjust.sv | 13 +
 rtl/bcd_to_bin.sv | 136 +++++++++++++
 tb/tb_bcd_to_bin.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary decoder.
// The optional invalid-digit check is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
package bcd_pkg;

    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BCD_BIN_W  = 14;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_OFFSET = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    // Reverse double-dabble correction applied to each nibble after the shift.
    function automatic logic [3:0] bcd_nibble_adjust(input logic [3:0] nib);
        return (nib >= BCD_ADJ_THRESH) ? (nib - BCD_ADJ_OFFSET) : nib;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational per-digit cell: a nibble of 8 or more has 3 subtracted.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = bcd_nibble_adjust(i_nib);
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary decoder, one reverse double-dabble step per clock.
// Define BCD2BIN_DIGIT_CHECK_EN to flag digits above 9 (err=1, bin_out=0).
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = BCD_DIGITS,
    parameter int unsigned BIN_W  = BCD_BIN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    bcd_state_t         r_state;
    bcd_state_t         w_state_nxt;
    logic [BCD_W-1:0]   r_bcd_sr;
    logic [BIN_W-1:0]   r_bin_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin_out;
    logic [BCD_W-1:0]   w_bcd_shift;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BIN_W-1:0]   w_bin_shift;
    logic [BIN_W-1:0]   w_bin_final;
    logic               w_accept;
    logic               w_last;

    assign w_bcd_shift = {1'b0, r_bcd_sr[BCD_W-1:1]};
    assign w_bin_shift = {r_bcd_sr[0], r_bin_sr[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_nib (w_bcd_shift[4*g +: 4]),
            .o_nib (w_bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic r_invalid;
    logic r_err;
    logic w_bad_digit;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    // Captured once at acceptance; the conversion still runs its full length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_invalid <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_invalid <= w_bad_digit;
        end else if (w_last) begin
            r_err     <= r_invalid;
        end
    end

    assign w_bin_final = r_invalid ? '0 : w_bin_shift;
    assign err         = r_err;
`else
    assign w_bin_final = w_bin_shift;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bcd_sr  <= '0;
            r_bin_sr  <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
        end else if (w_accept) begin
            r_bcd_sr  <= bcd_in;
            r_bin_sr  <= '0;
            r_cnt     <= CNT_W'(BIN_W);
        end else if (busy) begin
            r_bcd_sr  <= w_bcd_adj;
            r_bin_sr  <= w_bin_shift;
            r_cnt     <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_bin_out <= w_bin_final;
            end
        end
    end

    assign bin_out = r_bin_out;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: randomized BCD inputs against a decimal reference model.
module tb_bcd_to_bin;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BIN_W  = 14;

    logic                clk = 1'b0;
    logic                reset;
    logic                start = 1'b0;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    bin_out;
    logic                err;

    int n_vec = 0;
    int n_err = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always @(negedge clk) begin
        if (reset === 1'b1 && busy === 1'b1 && done === 1'b1) overlap_cnt++;
    end

    function automatic int unsigned ref_value(input logic [15:0] b);
        int unsigned v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic bit ref_bad(input logic [15:0] b);
        bit bad = 0;
        for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) bad = 1;
        return bad;
    endfunction

    function automatic logic [15:0] rand_valid_bcd();
        logic [15:0] b;
        for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

    // Drives one request from a negedge; returns what was seen at done (or seen=0 on timeout).
    task automatic run_conv(input logic [15:0] b, output logic [13:0] got_bin, output logic got_err,
                            output int busy_cnt, output int lat, output bit seen);
        busy_cnt = 0; lat = 0; seen = 0; got_bin = '0; got_err = 1'b0;
        bcd_in = b;
        start  = 1'b1;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            start  = 1'b0;
            bcd_in = 16'($urandom);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1; lat = c; got_bin = bin_out; got_err = err;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (bin_out !== 14'h0) begin n_err++; $display("FAIL reset_bin: got %h expected 0000", bin_out); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_single();
        logic [13:0] gb; logic ge; int bc, lat; bit seen;
        run_conv(16'h1234, gb, ge, bc, lat, seen);
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL single_done: got %b expected 1", seen); end
        n_vec++; if (lat != 15) begin n_err++; $display("FAIL single_latency: got %0d expected 15", lat); end
        n_vec++; if (bc != 14) begin n_err++; $display("FAIL single_busy_cycles: got %0d expected 14", bc); end
        n_vec++; if (gb !== 14'h04D2) begin n_err++; $display("FAIL single_bin: got %h expected 04d2", gb); end
        n_vec++; if (ge !== 1'b0) begin n_err++; $display("FAIL single_err: got %b expected 0", ge); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %b expected 0", done); end
        n_vec++; if (bin_out !== 14'h04D2) begin n_err++; $display("FAIL single_hold: got %h expected 04d2", bin_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [2] = '{16'h9999, 16'h0000};
        logic [13:0] gb; logic ge; int bc, lat; bit seen;
        for (int k = 0; k < 2; k++) begin
            run_conv(vals[k], gb, ge, bc, lat, seen);
            n_vec++; if (seen !== 1'b1 || lat != 15) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d expected 15", k, lat); end
            n_vec++; if (int'(gb) != ref_value(vals[k])) begin n_err++; $display("FAIL b2b_bin[%0d]: got %0d expected %0d", k, gb, ref_value(vals[k])); end
            @(negedge clk);
            n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL b2b_idle[%0d]: got busy=%b done=%b expected 0 0", k, busy, done); end
        end
    endtask

    task automatic test_random();
        logic [15:0] b; logic [13:0] gb; logic ge; int bc, lat; bit seen;
        for (int k = 0; k < 24; k++) begin
            b = rand_valid_bcd();
            run_conv(b, gb, ge, bc, lat, seen);
            n_vec++; if (seen !== 1'b1 || lat != 15 || bc != 14) begin n_err++; $display("FAIL rand_timing %h: got lat=%0d busy=%0d expected 15 14", b, lat, bc); end
            n_vec++; if (int'(gb) != ref_value(b) || ge !== 1'b0) begin n_err++; $display("FAIL rand_bin %h: got %0d err=%b expected %0d err=0", b, gb, ge, ref_value(b)); end
            if (k % 3 == 0) @(negedge clk);
            else repeat (1 + (k % 4)) @(negedge clk);
        end
    endtask

    task automatic test_start_during_busy();
        logic [15:0] b; logic [13:0] gb = '0; int dones = 0, lat = 0;
        b = rand_valid_bcd();
        bcd_in = b;
        start  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 5) ? 1'b1 : 1'b0;
            if (c == 5) bcd_in = 16'h5555;
            if (done) begin dones++; gb = bin_out; if (lat == 0) lat = c; end
        end
        n_vec++; if (dones != 1) begin n_err++; $display("FAIL busy_restart_dones: got %0d expected 1", dones); end
        n_vec++; if (int'(gb) != ref_value(b)) begin n_err++; $display("FAIL busy_restart_bin: got %0d expected %0d", gb, ref_value(b)); end
        n_vec++; if (lat != 15) begin n_err++; $display("FAIL busy_restart_latency: got %0d expected 15", lat); end
    endtask

    task automatic test_reset_abort();
        logic [13:0] gb; logic ge; int bc, lat; bit seen; int dones = 0;
        bcd_in = 16'h4321;
        start  = 1'b1;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_vec++; if (bin_out !== 14'h0) begin n_err++; $display("FAIL abort_bin: got %h expected 0000", bin_out); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
        run_conv(16'h4321, gb, ge, bc, lat, seen);
        n_vec++; if (seen !== 1'b1 || gb !== 14'h10E1 || lat != 15) begin n_err++; $display("FAIL abort_restart: got %h lat=%0d expected 10e1 lat=15", gb, lat); end
        @(negedge clk);
    endtask

    task automatic test_digit_check();
        logic [15:0] b; logic [13:0] gb; logic ge; int bc, lat; bit seen;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) b = 16'h12A4;
            else begin
                b = rand_valid_bcd();
                b[4*(k % 4) +: 4] = 4'($urandom_range(10, 15));
            end
            run_conv(b, gb, ge, bc, lat, seen);
            n_vec++; if (seen !== 1'b1 || lat != 15) begin n_err++; $display("FAIL check_latency %h: got %0d expected 15", b, lat); end
`ifdef BCD2BIN_DIGIT_CHECK_EN
            n_vec++; if (ge !== ref_bad(b)) begin n_err++; $display("FAIL check_err %h: got %b expected %b", b, ge, ref_bad(b)); end
            n_vec++; if (gb !== 14'h0) begin n_err++; $display("FAIL check_bin %h: got %h expected 0000", b, gb); end
`else
            n_vec++; if (ge !== 1'b0) begin n_err++; $display("FAIL check_err %h: got %b expected 0", b, ge); end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_exclusive();
        n_vec++; if (overlap_cnt != 0) begin n_err++; $display("FAIL busy_done_overlap: got %0d cycles expected 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_start_during_busy();
        test_reset_abort();
        test_digit_check();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
